// File: rtl/recovery_ctrl_pkg.sv
// Shared types for the mispredict recovery controller: FSM state encoding
// and the functional-unit count that sizes the busy bus.
package recovery_ctrl_pkg;
  localparam int NUM_FU = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    FLUSH    = 3'd2,
    SETTLE   = 3'd3,
    REDIRECT = 3'd4
  } recovery_state_t;
endpackage

// File: rtl/recovery_ctrl.sv
// Branch mispredict recovery: drain an in-flight store, flush the machine,
// wait for the FUs to quiesce, then redirect fetch to the latched PC.
module recovery_ctrl
  import recovery_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int DRAIN_MAX     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mispredict_in,
  input  logic [31:0]       redirect_pc_in,
  input  logic              store_inflight,
  input  logic [NUM_FU-1:0] fu_busy_bus,
  output logic              flush,
  output logic              fetch_stall,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              busy,
  output logic              drain_timeout,
  output logic              overlap_err,
  output logic [15:0]       flush_count
);
  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);
  localparam logic [3:0] LP_DRAIN  = 4'(DRAIN_MAX);

  recovery_state_t r_state;
  logic [31:0]     r_pc;
  logic [3:0]      r_wait_cnt;
  logic [3:0]      r_settle_cnt;
  logic            r_drain_to;
  logic            r_overlap;
  logic [15:0]     r_flush_cnt;

  logic [3:0]      w_wait_nxt;
  logic [3:0]      w_settle_nxt;

  assign w_wait_nxt   = r_wait_cnt + 4'd1;
  assign w_settle_nxt = (r_settle_cnt == 4'd0) ? 4'd0 : r_settle_cnt - 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_wait_cnt   <= '0;
      r_settle_cnt <= '0;
      r_drain_to   <= 1'b0;
      r_overlap    <= 1'b0;
      r_flush_cnt  <= '0;
    end else begin
      if (mispredict_in && r_state != IDLE) r_overlap <= 1'b1;
      case (r_state)
        IDLE: begin
          if (mispredict_in) begin
            r_pc       <= redirect_pc_in;
            r_wait_cnt <= '0;
            r_state    <= store_inflight ? DRAIN : FLUSH;
          end
        end
        DRAIN: begin
          r_wait_cnt <= w_wait_nxt;
          if (!store_inflight) begin
            r_state <= FLUSH;
          end else if (w_wait_nxt == LP_DRAIN) begin
            r_state    <= FLUSH;
            r_drain_to <= 1'b1;
          end
        end
        FLUSH: begin
          r_settle_cnt <= LP_SETTLE;
          r_state      <= SETTLE;
        end
        SETTLE: begin
          // Exit on the post-decrement value so SETTLE lasts exactly SETTLE_CYCLES when idle.
          r_settle_cnt <= w_settle_nxt;
          if (w_settle_nxt == 4'd0 && fu_busy_bus == '0) r_state <= REDIRECT;
        end
        REDIRECT: begin
          if (r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign flush          = (r_state == FLUSH);
  assign redirect_valid = (r_state == REDIRECT);
  assign busy           = (r_state != IDLE);
  assign fetch_stall    = (r_state != IDLE);
  assign redirect_pc    = r_pc;
  assign drain_timeout  = r_drain_to;
  assign overlap_err    = r_overlap;
  assign flush_count    = r_flush_cnt;
endmodule

// File: tb/tb_recovery_ctrl.sv
// Directed bench for recovery_ctrl; accepted mispredicts queue their expected
// redirect PC and recovery count, which are checked when the redirect appears.
module tb_recovery_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        mispredict_in;
  logic [31:0] redirect_pc_in;
  logic        store_inflight;
  logic [3:0]  fu_busy_bus;
  logic        flush, fetch_stall, redirect_valid, busy, drain_timeout, overlap_err;
  logic [31:0] redirect_pc;
  logic [15:0] flush_count;

  recovery_ctrl dut (
    .clk(clk), .reset(reset), .mispredict_in(mispredict_in),
    .redirect_pc_in(redirect_pc_in), .store_inflight(store_inflight),
    .fu_busy_bus(fu_busy_bus), .flush(flush), .fetch_stall(fetch_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
    .drain_timeout(drain_timeout), .overlap_err(overlap_err),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] cur_cnt = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flush"},   {31'd0, flush},          32'd0);
    chk({tag, "_stall"},   {31'd0, fetch_stall},    32'd0);
    chk({tag, "_rv"},      {31'd0, redirect_valid}, 32'd0);
    chk({tag, "_busy"},    {31'd0, busy},           32'd0);
    chk({tag, "_dto"},     {31'd0, drain_timeout},  32'd0);
    chk({tag, "_ovl"},     {31'd0, overlap_err},    32'd0);
    chk({tag, "_pc"},      redirect_pc,             32'd0);
    chk({tag, "_fcnt"},    {16'd0, flush_count},    32'd0);
  endtask

  // Drives a one-cycle mispredict; afterwards the bench sits in cycle T+1.
  task automatic start_mp(input logic [31:0] pc, input bit accept);
    mispredict_in  = 1'b1;
    redirect_pc_in = pc;
    if (accept) begin
      exp_cnt = exp_cnt + 16'd1;
      sb.push_back('{pc, exp_cnt});
    end
    tick();
    mispredict_in  = 1'b0;
    redirect_pc_in = 32'hDEAD_BEEF;
  endtask

  // Waits for redirect_valid, counting cycles and stray flush pulses, then
  // checks the PC against the scoreboard head.
  task automatic wait_redirect(input string tag, input int budget,
                               output int ticks, output int flushes);
    ticks   = 0;
    flushes = 0;
    while (redirect_valid !== 1'b1 && ticks < budget) begin
      if (flush === 1'b1) flushes++;
      tick();
      ticks++;
    end
    chk({tag, "_rv_seen"}, {31'd0, redirect_valid}, 32'd1);
    chk({tag, "_sb_head"}, {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({tag, "_redir_pc"}, redirect_pc, e.pc);
      cur_cnt = e.cnt;
    end
  endtask

  initial begin
    int lat, nfl, n;
    int rv_seen, fl_seen;
    reset = 1'b1; mispredict_in = 1'b0; redirect_pc_in = '0;
    store_inflight = 1'b0; fu_busy_bus = '0;
    repeat (3) tick();
    chk_all_zero("rst");
    reset = 1'b0;
    tick();

    // Basic recovery: flush at T+1 only, redirect at T+4.
    start_mp(32'h0000_0040, 1'b1);
    chk("t1_flush_T1", {31'd0, flush}, 32'd1);
    chk("t1_busy_T1",  {31'd0, busy},  32'd1);
    tick();
    chk("t1_flush_T2", {31'd0, flush}, 32'd0);
    chk("t1_stall_T2", {31'd0, fetch_stall}, 32'd1);
    tick();
    chk("t1_flush_T3", {31'd0, flush}, 32'd0);
    chk("t1_rv_T3",    {31'd0, redirect_valid}, 32'd0);
    chk("t1_pc_hold",  redirect_pc, 32'h40);
    tick();
    wait_redirect("t1", 10, lat, nfl);
    chk("t1_rv_lat", lat, 0);
    tick();
    chk("t1_fcnt", {16'd0, flush_count}, {16'd0, cur_cnt});
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Store in flight for 3 cycles: flush slips from T+1 to T+4.
    store_inflight = 1'b1;
    start_mp(32'h0000_0100, 1'b1);
    chk("t2_flush_T1", {31'd0, flush}, 32'd0);
    tick();
    chk("t2_flush_T2", {31'd0, flush}, 32'd0);
    tick();
    store_inflight = 1'b0;
    chk("t2_flush_T3", {31'd0, flush}, 32'd0);
    tick();
    chk("t2_flush_T4", {31'd0, flush}, 32'd1);
    chk("t2_dto", {31'd0, drain_timeout}, 32'd0);
    wait_redirect("t2", 10, lat, nfl);
    chk("t2_rv_lat", lat, 3);
    tick();
    chk("t2_fcnt", {16'd0, flush_count}, {16'd0, cur_cnt});

    // FU busy for 6 cycles after flush holds SETTLE until the bus clears.
    start_mp(32'h0000_0200, 1'b1);
    chk("t3_flush", {31'd0, flush}, 32'd1);
    tick();
    fu_busy_bus = 4'b1000;
    repeat (6) begin
      tick();
      chk("t3_rv_held", {31'd0, redirect_valid}, 32'd0);
    end
    fu_busy_bus = 4'b0000;
    tick();
    wait_redirect("t3", 10, lat, nfl);
    chk("t3_rv_lat", lat, 0);
    tick();
    chk("t3_fcnt", {16'd0, flush_count}, {16'd0, cur_cnt});
    chk("t3_ovl_clear", {31'd0, overlap_err}, 32'd0);

    // Second mispredict during SETTLE is ignored and flagged.
    start_mp(32'h0000_0040, 1'b1);
    tick();
    start_mp(32'h0000_0080, 1'b0);
    chk("t4_ovl", {31'd0, overlap_err}, 32'd1);
    chk("t4_flush", {31'd0, flush}, 32'd0);
    wait_redirect("t4", 10, lat, nfl);
    chk("t4_rv_lat", lat, 1);
    chk("t4_one_flush", nfl, 0);
    tick();
    chk("t4_fcnt", {16'd0, flush_count}, {16'd0, cur_cnt});

    // Store never completes: 15 DRAIN cycles, then forced flush with timeout flag.
    store_inflight = 1'b1;
    start_mp(32'h0000_0300, 1'b1);
    chk("t5_dto_early", {31'd0, drain_timeout}, 32'd0);
    n = 0;
    while (flush !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t5_drain_len", n, 15);
    chk("t5_dto", {31'd0, drain_timeout}, 32'd1);
    store_inflight = 1'b0;
    wait_redirect("t5", 10, lat, nfl);
    chk("t5_rv_lat", lat, 3);
    tick();
    chk("t5_fcnt", {16'd0, flush_count}, {16'd0, cur_cnt});

    // Reset in SETTLE (with a coincident mispredict) aborts silently.
    start_mp(32'h0000_0500, 1'b0);
    tick();
    reset = 1'b1;
    mispredict_in = 1'b1;
    redirect_pc_in = 32'h0000_0900;
    tick();
    mispredict_in = 1'b0;
    chk_all_zero("t6");
    reset = 1'b0;
    exp_cnt = '0;
    rv_seen = 0;
    fl_seen = 0;
    repeat (8) begin
      tick();
      if (redirect_valid === 1'b1) rv_seen++;
      if (flush === 1'b1) fl_seen++;
    end
    chk("t6_no_rv", rv_seen, 0);
    chk("t6_no_flush", fl_seen, 0);
    chk("t6_idle", {31'd0, busy}, 32'd0);

    // Mispredict arriving while REDIRECT returns to IDLE is not accepted.
    start_mp(32'h0000_0600, 1'b1);
    chk("t7_flush", {31'd0, flush}, 32'd1);
    repeat (3) tick();
    wait_redirect("t7", 10, lat, nfl);
    chk("t7_rv_lat", lat, 0);
    start_mp(32'h0000_0700, 1'b0);
    chk("t7_idle", {31'd0, busy}, 32'd0);
    chk("t7_pc_kept", redirect_pc, 32'h600);
    chk("t7_fcnt", {16'd0, flush_count}, {16'd0, cur_cnt});
    tick();
    chk("t7_no_flush", {31'd0, flush}, 32'd0);
    chk("t7_still_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
